// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule generator.
//   - key-length helpers: NK (key words), NR (rounds), NW (schedule words)
//   - xtime: GF(2^8) multiply-by-x, used to advance the round constant
//   - FSM state encoding for the schedule generator
//   - forward S-box table used by SubWord
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (key_bits / 32 + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES forward S-box to each byte of a 32-bit word.
// Ports:
//   word_i  32-bit input word
//   word_o  32-bit substituted word (purely combinational)
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_sched_iter.sv
// Word-serial AES key-schedule generator (KEY_BITS = 128/192/256).
// Produces one schedule word per non-stalled cycle and delivers the NR+1
// round keys, in order, over a valid/ready stream.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   scan_enable           1 = scan mode, functional state frozen
//   scan_ck_en            in scan mode, shift the chain by one bit
//   scan_input/output     chain serial in / out (out = MSB of rk)
//   start, key            begin expansion of key (sampled in IDLE only)
//   busy                  expansion in progress (GEN or DRAIN)
//   rk, rk_idx, rk_last   round key r, its index, and r == NR
//   rk_valid, rk_ready    output handshake
//
// Handshake: a round key transfers when rk_valid & rk_ready are both high at
// a rising edge; while rk_valid & ~rk_ready the output register is held, and
// rk_valid never drops without a transfer.
module aes_key_sched_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_enable,
  input  logic                scan_ck_en,
  input  logic                scan_input,
  output logic                scan_output,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic                busy,
  output logic [127:0]        rk,
  output logic [3:0]          rk_idx,
  output logic                rk_last,
  output logic                rk_valid,
  input  logic                rk_ready
);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_sched_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam logic [5:0] NK6 = 6'(NK);
  localparam logic [5:0] NW6 = 6'(NW);
  localparam int CHAIN_LEN = 128 + 4 + 1 + 128 + KEY_BITS + 8 + 6 + 2;

  logic [1:0]          state_q, state_d;
  logic [5:0]          wi_q, wi_d;
  logic [7:0]          rcon_q, rcon_d;
  // Window holds the last NK words, oldest (w[wi-NK]) in the MSB word.
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [127:0]        buf_q, buf_d;
  logic [127:0]        rk_q, rk_d;
  logic [3:0]          idx_q, idx_d;
  logic                vld_q, vld_d;

  logic [31:0] w_old, w_prev, w_new, temp, sub_in, sub_out;
  logic [5:0]  wi_mod;
  logic        complete, stall;
  logic [CHAIN_LEN-1:0] chain;

  assign w_old  = win_q[KEY_BITS-1 -: 32];
  assign w_prev = win_q[31:0];
  assign wi_mod = wi_q % NK6;

  // Only the wi mod NK == 0 case needs RotWord before the S-box.
  assign sub_in = (wi_mod == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (wi_mod == 6'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && wi_mod == 6'd4) begin
      temp = sub_out;
    end
  end

  // During the first NK words the window simply rotates, so the key words
  // come out in order and the window is back in schedule order at wi == NK.
  assign w_new = (wi_q < NK6) ? w_old : (w_old ^ temp);

  assign complete = (wi_q[1:0] == 2'b11);
  assign stall    = complete & vld_q & ~rk_ready;

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    rcon_d  = rcon_q;
    win_d   = win_q;
    buf_d   = buf_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    vld_d   = vld_q;

    if (vld_q && rk_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = key;
          wi_d    = 6'd0;
          rcon_d  = 8'h01;
          state_d = GEN;
        end
      end
      GEN: begin
        if (!stall) begin
          win_d = {win_q[KEY_BITS-33:0], w_new};
          buf_d = {buf_q[95:0], w_new};
          wi_d  = wi_q + 6'd1;
          if (wi_q >= NK6 && wi_mod == 6'd0) begin
            rcon_d = xtime(rcon_q);
          end
          // The completing word bypasses the buffer straight into rk.
          if (complete) begin
            rk_d  = {buf_q[95:0], w_new};
            idx_d = wi_q[5:2];
            vld_d = 1'b1;
          end
          if (wi_q == NW6 - 6'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (vld_q && rk_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chain MSB-first: scan_input enters at state, leaves from the rk MSB.
  assign chain = {rk_q, idx_q, vld_q, buf_q, win_q, rcon_q, wi_q, state_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wi_q    <= 6'd0;
      rcon_q  <= 8'h01;
      win_q   <= '0;
      buf_q   <= '0;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      vld_q   <= 1'b0;
    end else if (scan_enable) begin
      if (scan_ck_en) begin
        {rk_q, idx_q, vld_q, buf_q, win_q, rcon_q, wi_q, state_q} <=
          {chain[CHAIN_LEN-2:0], scan_input};
      end
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      rcon_q  <= rcon_d;
      win_q   <= win_d;
      buf_q   <= buf_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign scan_output = rk_q[127];
  assign busy        = (state_q == GEN) || (state_q == DRAIN);
  assign rk          = rk_q;
  assign rk_idx      = idx_q;
  assign rk_valid    = vld_q;
  assign rk_last     = (idx_q == 4'(NR));

endmodule
